chunk_serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
- Uses a start/busy/done handshake and holds its results until the next operation.
- Sits between board pin/switch logic and display/LED logic; trades latency for small area at large WIDTH.

---
 rtl/chunk_serial_adder_pkg.sv | 23 ++
 rtl/chunk_serial_adder_add.sv | 24 ++
 rtl/chunk_serial_adder.sv | 129 ++++++++++++
 tb/tb_chunk_serial_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_serial_adder_pkg.sv
// rtl/chunk_serial_adder_pkg.sv - shared types and elaboration checks for chunk_serial_adder
//
// Holds the FSM state encoding used by the top.
// Also defines CSA_WIDTH_CHECK, which stops elaboration when WIDTH is not
// an exact multiple of CHUNK.
// No ports.

package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`ifndef CSA_WIDTH_CHECK
`define CSA_WIDTH_CHECK(W, C) \
  if (((W) % (C)) != 0) begin : g_width_check \
    $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK"); \
  end
`endif

// File: rtl/chunk_serial_adder_add.sv
// rtl/chunk_serial_adder_add.sv - combinational CHUNK-bit adder slice
//
// Ports:
//   x  [CHUNK]  in   chunk of operand A
//   y  [CHUNK]  in   chunk of operand B (already inverted for subtract)
//   ci          in   carry into the chunk
//   s  [CHUNK]  out  chunk sum
//   co          out  carry out of the chunk

module chunk_add
  import chunk_serial_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   request an operation (sampled in IDLE only)
//   a, b [WIDTH]   in   operands, captured on the accepting edge
//   cin            in   carry-in for add mode
//   sub            in   0: a+b+cin, 1: a-b
//   busy           out  operation in progress
//   done           out  one-cycle pulse, results valid from this cycle
//   sum  [WIDTH]   out  result, held until the next accepted start
//   cout           out  carry out of MSB (sub mode: 1 = no borrow)
//   ovf            out  two's-complement overflow

module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  `CSA_WIDTH_CHECK(WIDTH, CHUNK)

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] opa_chunk;
  logic [CHUNK-1:0] opb_chunk;
  logic [CHUNK-1:0] sum_chunk_d;
  logic             carry_d;

  assign opa_chunk = opa_q[idx_q*CHUNK +: CHUNK];
  assign opb_chunk = opb_q[idx_q*CHUNK +: CHUNK];

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x  (opa_chunk),
    .y  (opb_chunk),
    .ci (carry_q),
    .s  (sum_chunk_d),
    .co (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the inverted operand and the
            // forced carry-in are set up once here; RUN never looks at sub.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= sum_chunk_d;
          carry_q <= carry_d;
          if (idx_q == LAST) begin
            cout_q  <= carry_d;
            // opb_q already holds ~b in sub mode, so one formula covers both.
            ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                       (sum_chunk_d[CHUNK-1] != opa_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - directed and swept checks of chunk_serial_adder

module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        st0, st1, st2;

  logic        busy0, done0, cout0, ovf0;
  logic        busy1, done1, cout1, ovf1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] sum0, sum1, sum2;

  int          sel;
  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  assign m_busy = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy0;
  assign m_done = (sel == 1) ? done1 : (sel == 2) ? done2 : done0;
  assign m_sum  = (sel == 1) ? sum1  : (sel == 2) ? sum2  : sum0;
  assign m_cout = (sel == 1) ? cout1 : (sel == 2) ? cout2 : cout0;
  assign m_ovf  = (sel == 1) ? ovf1  : (sel == 2) ? ovf2  : ovf0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: native subtraction / 17-bit addition.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [16:0] r;
    logic [15:0] s;
    logic        co, ov;
    if (ms) begin
      s  = ma - mb;
      co = (ma >= mb);
      ov = (ma[15] != mb[15]) && (s[15] != ma[15]);
    end else begin
      r  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
      s  = r[15:0];
      co = r[16];
      ov = (ma[15] == mb[15]) && (s[15] != ma[15]);
    end
    return {ov, co, s};
  endfunction

  // Launch one operation on the selected DUT and wait (bounded) for done.
  // lat = edges after the accepting edge until done is seen; nbusy = cycles
  // with busy high before done; dn_after = done one cycle after the pulse.
  task automatic op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                    input logic ts, input int s_i,
                    output int lat, output int nbusy, output logic dn_after);
    @(negedge clk);
    sel = s_i;
    a = ta; b = tb; cin = tc; sub = ts;
    st0 = (s_i == 0); st1 = (s_i == 1); st2 = (s_i == 2);
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!m_done && lat < 40) begin
      if (m_busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op(output logic dn_after);
    @(posedge clk); #1;
    dn_after = m_done;
  endtask

  initial begin
    int          lat, nbusy, ndone;
    logic        dn;
    logic [17:0] ref_v;
    logic [15:0] ra, rb;
    logic        rc, rs;

    sel = 0; rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_sum",  sum0,  0);
    chk("rst_cout", cout0, 0);
    chk("rst_ovf",  ovf0,  0);
    @(negedge clk); rst_n = 1'b1;

    // 0xFFFF + 0x0001: latency, busy length, wrap-around
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, lat, nbusy, dn);
    chk("t1_lat",   lat,   4);
    chk("t1_busy",  nbusy, 4);
    chk("t1_sum",   m_sum, 16'h0000);
    chk("t1_cout",  m_cout, 1);
    chk("t1_ovf",   m_ovf,  0);
    finish_op(dn);
    chk("t1_done_pulse", dn, 0);
    chk("t1_busy_idle",  m_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_sum_hold",  m_sum,  16'h0000);
    chk("t1_cout_hold", m_cout, 1);

    // 0x7FFF + 1 -> signed overflow
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat, nbusy, dn);
    chk("t2_sum",  m_sum,  16'h8000);
    chk("t2_cout", m_cout, 0);
    chk("t2_ovf",  m_ovf,  1);
    finish_op(dn);

    // 0x1234 + 0x1111 + cin
    op(16'h1234, 16'h1111, 1'b1, 1'b0, 0, lat, nbusy, dn);
    chk("t3_sum",  m_sum,  16'h2346);
    chk("t3_cout", m_cout, 0);
    chk("t3_ovf",  m_ovf,  0);
    finish_op(dn);

    // 5 - 7, cin ignored in sub mode
    op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, lat, nbusy, dn);
    chk("t4_sum",  m_sum,  16'hFFFE);
    chk("t4_cout", m_cout, 0);
    chk("t4_ovf",  m_ovf,  0);
    finish_op(dn);

    // 0x8000 - 1 -> signed overflow, no borrow
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, lat, nbusy, dn);
    chk("t5_sum",  m_sum,  16'h7FFF);
    chk("t5_cout", m_cout, 1);
    chk("t5_ovf",  m_ovf,  1);
    finish_op(dn);

    // Async reset in the 2nd RUN cycle (cout/ovf still hold 1 from above)
    sel = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    @(posedge clk); #2;
    chk("r_busy_before", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy0, 0);
    chk("r_done", done0, 0);
    chk("r_sum",  sum0,  0);
    chk("r_cout", cout0, 0);
    chk("r_ovf",  ovf0,  0);
    @(posedge clk); #1;
    chk("r_busy_held", busy0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("r_no_resume", busy0 | done0, 0);
    op(16'hABCD, 16'h1234, 1'b0, 1'b0, 0, lat, nbusy, dn);
    chk("r_new_lat",  lat,    4);
    chk("r_new_sum",  m_sum,  16'hBE01);
    chk("r_new_cout", m_cout, 0);
    chk("r_new_ovf",  m_ovf,  0);
    finish_op(dn);

    // Operand changes and a second start inside RUN are ignored
    sel = 0;
    @(negedge clk);
    a = 16'h00F0; b = 16'h0F00; cin = 1'b0; sub = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done0) begin
        ndone++;
        chk("ig_sum",  sum0,  16'h0FF0);
        chk("ig_cout", cout0, 0);
        chk("ig_ovf",  ovf0,  0);
      end
      @(posedge clk); #1;
    end
    chk("ig_done_count", ndone, 1);
    chk("ig_idle", busy0, 0);

    // CHUNK=1 sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      ref_v = model(ra, rb, rc, rs);
      op(ra, rb, rc, rs, 1, lat, nbusy, dn);
      chk("c1_lat",  lat,    16);
      chk("c1_sum",  m_sum,  ref_v[15:0]);
      chk("c1_cout", m_cout, ref_v[16]);
      chk("c1_ovf",  m_ovf,  ref_v[17]);
      finish_op(dn);
    end

    // CHUNK=16 sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      ref_v = model(ra, rb, rc, rs);
      op(ra, rb, rc, rs, 2, lat, nbusy, dn);
      chk("c16_lat",  lat,    1);
      chk("c16_sum",  m_sum,  ref_v[15:0]);
      chk("c16_cout", m_cout, ref_v[16]);
      chk("c16_ovf",  m_ovf,  ref_v[17]);
      finish_op(dn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
